// File: rtl/sram_like_slave.sv
// sram_like_slave
//
// Responder for the SRAM-like req/addr_ok/data_ok handshake. It accepts address-phase
// requests, drives a single-port synchronous RAM in the accept cycle, and returns
// in-order responses from a DEPTH-entry queue. A read's data is written into its queue
// entry one cycle after the RAM access. If that entry is already at the head, the data
// is forwarded straight from ram_rdata. With DELAY_EN=1 an LFSR inserts random stalls on
// both phases. These stalls exercise the initiator's buffering logic.
//
// Parameters:
//   DEPTH      maximum outstanding requests (power of two, 2..8)
//   RAM_AW     RAM word-address width
//   DELAY_EN   1 enables random addr_ok / data_ok stalls
//   DELAY_BITS width of each random stall count
//   LFSR_SEED  non-zero LFSR reset value
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   sram_req/wr/size/addr/      request phase from the initiator
//   wstrb/wdata
//   sram_addr_ok                request accepted this cycle (when sram_req=1)
//   sram_data_ok, sram_rdata    one in-order response per data_ok; rdata=0 otherwise
//   ram_en/we/addr/wdata        RAM access, asserted only in the accept cycle
//   ram_rdata                   RAM read data, valid the cycle after ram_en
module sram_like_slave #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RAM_AW     = 16,
  parameter bit          DELAY_EN   = 1'b0,
  parameter int unsigned DELAY_BITS = 2,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sram_req,
  input  logic              sram_wr,
  input  logic [1:0]        sram_size,
  input  logic [31:0]       sram_addr,
  input  logic [3:0]        sram_wstrb,
  input  logic [31:0]       sram_wdata,
  output logic              sram_addr_ok,
  output logic              sram_data_ok,
  output logic [31:0]       sram_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  // Response queue state. A write entry is pushed already filled, so the filled bit
  // alone determines whether the head is ready. A separate is_write bit is not needed.
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [31:0]     data_q [DEPTH];
  logic [31:0]     data_d [DEPTH];

  // The read accepted in the previous cycle, whose RAM data is arriving now.
  logic            rd_pend_q, rd_pend_d;
  logic [PtrW-1:0] rd_idx_q, rd_idx_d;

  // Stall generation.
  logic [15:0]           lfsr_q, lfsr_d;
  logic                  lfsr_fb;
  logic [DELAY_BITS-1:0] addr_wait_q, addr_wait_d;
  logic [DELAY_BITS-1:0] data_wait_q, data_wait_d;

  logic addr_ok;
  logic accept;
  logic bypass;
  logic head_ready;
  logic data_ok;

  // Size is informational. Address bits outside the word index are ignored.
  logic unused_inputs;
  assign unused_inputs = ^{sram_size, sram_addr};

  // The addr_ok full check uses the registered count only. A full queue therefore
  // refuses a request even in a cycle where it is also retiring the head.
  assign addr_ok    = resetn & (count_q < Full) & (addr_wait_q == '0);
  assign accept     = sram_req & addr_ok;
  assign bypass     = rd_pend_q & (rd_idx_q == head_q);
  assign head_ready = filled_q[head_q] | bypass;
  assign data_ok    = resetn & (count_q != '0) & (data_wait_q == '0) & head_ready;

  // RAM side: driven combinationally in the accept cycle only.
  assign ram_en    = accept;
  assign ram_we    = (accept & sram_wr) ? sram_wstrb : 4'h0;
  assign ram_addr  = sram_addr[RAM_AW+1:2];
  assign ram_wdata = sram_wdata;

  // Initiator side.
  assign sram_addr_ok = addr_ok;
  assign sram_data_ok = data_ok;
  assign sram_rdata   = !data_ok ? 32'h0 :
                        bypass   ? ram_rdata : data_q[head_q];

  // Queue next-state. Within this block the order of updates matters:
  // the fill runs before the pop so the pop can clear a bypassed entry,
  // and the push runs last.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    filled_d  = filled_q;
    data_d    = data_q;
    rd_pend_d = accept & ~sram_wr;
    rd_idx_d  = tail_q;

    if (rd_pend_q) begin
      data_d[rd_idx_q]   = ram_rdata;
      filled_d[rd_idx_q] = 1'b1;
    end

    if (data_ok) begin
      filled_d[head_q] = 1'b0;
      head_d           = head_q + 1'b1;
    end

    if (accept) begin
      filled_d[tail_q] = sram_wr;
      data_d[tail_q]   = 32'h0;
      tail_d           = tail_q + 1'b1;
    end

    unique case ({accept, data_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Fibonacci LFSR, taps 16,14,13,11. Each wait counter reloads from its own
  // slice of the LFSR on its handshake and then counts down to zero.
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_comb begin
    lfsr_d      = {lfsr_q[14:0], lfsr_fb};
    addr_wait_d = addr_wait_q;
    data_wait_d = data_wait_q;

    if (!DELAY_EN) begin
      addr_wait_d = '0;
      data_wait_d = '0;
    end else begin
      if (accept) begin
        addr_wait_d = lfsr_q[DELAY_BITS-1:0];
      end else if (addr_wait_q != '0) begin
        addr_wait_d = addr_wait_q - 1'b1;
      end

      if (data_ok) begin
        data_wait_d = lfsr_q[DELAY_BITS +: DELAY_BITS];
      end else if (data_wait_q != '0) begin
        data_wait_d = data_wait_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      filled_q    <= '0;
      rd_pend_q   <= 1'b0;
      rd_idx_q    <= '0;
      lfsr_q      <= LFSR_SEED;
      addr_wait_q <= '0;
      data_wait_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      filled_q    <= filled_d;
      rd_pend_q   <= rd_pend_d;
      rd_idx_q    <= rd_idx_d;
      lfsr_q      <= lfsr_d;
      addr_wait_q <= addr_wait_d;
      data_wait_q <= data_wait_d;
    end
  end

  // Entry payload has no reset. An entry's data is only read after it has been
  // pushed, and its filled bit has been set.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule

// File: tb/tb_sram_like_slave.sv
// Bench for sram_like_slave: two instances sharing clock and reset.
//   u_dut0: DEPTH=4, no delay  -> exact T+1 latency and directed data checks.
//   u_dut1: DEPTH=2, delay on  -> random traffic, in-order scoreboard, full-queue rule.
// The reference model holds one word array per instance, updated at the accept cycle,
// plus a queue of expected responses.
module tb_sram_like_slave;

  localparam int unsigned AW = 8;
  localparam int unsigned D0 = 4;
  localparam int unsigned D1 = 2;
  localparam int unsigned NW = 2 ** AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  logic          req0, wr0, aok0, dok0, ren0;
  logic [1:0]    size0;
  logic [3:0]    wstrb0, rwe0;
  logic [31:0]   addr0, wdata0, rdata0, rwdata0, rrdata0;
  logic [AW-1:0] raddr0;

  logic          req1, wr1, aok1, dok1, ren1;
  logic [1:0]    size1;
  logic [3:0]    wstrb1, rwe1;
  logic [31:0]   addr1, wdata1, rdata1, rwdata1, rrdata1;
  logic [AW-1:0] raddr1;

  sram_like_slave #(
    .DEPTH(D0), .RAM_AW(AW), .DELAY_EN(1'b0), .DELAY_BITS(2), .LFSR_SEED(16'hACE1)
  ) u_dut0 (
    .clk(clk), .resetn(resetn),
    .sram_req(req0), .sram_wr(wr0), .sram_size(size0), .sram_addr(addr0),
    .sram_wstrb(wstrb0), .sram_wdata(wdata0),
    .sram_addr_ok(aok0), .sram_data_ok(dok0), .sram_rdata(rdata0),
    .ram_en(ren0), .ram_we(rwe0), .ram_addr(raddr0), .ram_wdata(rwdata0),
    .ram_rdata(rrdata0)
  );

  sram_like_slave #(
    .DEPTH(D1), .RAM_AW(AW), .DELAY_EN(1'b1), .DELAY_BITS(3), .LFSR_SEED(16'h1D2C)
  ) u_dut1 (
    .clk(clk), .resetn(resetn),
    .sram_req(req1), .sram_wr(wr1), .sram_size(size1), .sram_addr(addr1),
    .sram_wstrb(wstrb1), .sram_wdata(wdata1),
    .sram_addr_ok(aok1), .sram_data_ok(dok1), .sram_rdata(rdata1),
    .ram_en(ren1), .ram_we(rwe1), .ram_addr(raddr1), .ram_wdata(rwdata1),
    .ram_rdata(rrdata1)
  );

  // Synchronous RAMs. Garbage is driven whenever no read is due, which exposes any
  // use of ram_rdata outside the cycle after ram_en.
  logic [31:0] mem0 [NW];
  logic [31:0] mem1 [NW];

  always @(posedge clk) begin
    if (ren0) begin
      for (int b = 0; b < 4; b++) if (rwe0[b]) mem0[raddr0][8*b +: 8] <= rwdata0[8*b +: 8];
      rrdata0 <= mem0[raddr0];
    end else begin
      rrdata0 <= $urandom();
    end
  end

  always @(posedge clk) begin
    if (ren1) begin
      for (int b = 0; b < 4; b++) if (rwe1[b]) mem1[raddr1][8*b +: 8] <= rwdata1[8*b +: 8];
      rrdata1 <= mem1[raddr1];
    end else begin
      rrdata1 <= $urandom();
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model.
  logic [31:0] ref0 [NW];
  logic [31:0] ref1 [NW];
  logic [31:0] exp0_q [$];
  logic [31:0] exp1_q [$];
  logic        prev_acc0;
  int          out1;

  // Monitor: samples every cycle at the falling edge, when the inputs are stable.
  always @(negedge clk) begin : mon
    logic acc0, acc1;
    int   idx;
    acc0 = req0 & aok0;
    acc1 = req1 & aok1;
    if (!resetn) begin
      check("rst_addr_ok0", aok0, 0);
      check("rst_data_ok0", dok0, 0);
      check("rst_rdata0", rdata0, 0);
      check("rst_ram_en0", ren0, 0);
      check("rst_ram_we0", rwe0, 0);
      check("rst_addr_ok1", aok1, 0);
      check("rst_data_ok1", dok1, 0);
      exp0_q.delete();
      exp1_q.delete();
      prev_acc0 = 1'b0;
      out1      = 0;
    end else begin
      // Zero-delay instance: always ready, and each response arrives exactly one cycle
      // after its accept.
      check("addr_ok0", aok0, 1);
      check("data_ok0_latency", dok0, prev_acc0);
      if (dok0) begin
        if (exp0_q.size() == 0) check("spurious_data_ok0", dok0, 0);
        else check("rdata0", rdata0, exp0_q.pop_front());
      end else begin
        check("idle_rdata0", rdata0, 0);
      end
      check("ram_en0", ren0, acc0);
      if (acc0) begin
        idx = int'(addr0[AW+1:2]);
        check("ram_addr0", raddr0, addr0[AW+1:2]);
        check("ram_we0", rwe0, wr0 ? wstrb0 : 4'h0);
        if (wr0) begin
          check("ram_wdata0", rwdata0, wdata0);
          for (int b = 0; b < 4; b++) if (wstrb0[b]) ref0[idx][8*b +: 8] = wdata0[8*b +: 8];
          exp0_q.push_back(32'h0);
        end else begin
          exp0_q.push_back(ref0[idx]);
        end
      end
      prev_acc0 = acc0;

      // Delayed instance: a full queue must refuse requests, even in a cycle where it
      // also retires an entry.
      if (out1 == int'(D1)) check("full_addr_ok1", aok1, 0);
      if (dok1) begin
        if (exp1_q.size() == 0) check("spurious_data_ok1", dok1, 0);
        else check("rdata1", rdata1, exp1_q.pop_front());
        out1--;
      end else begin
        check("idle_rdata1", rdata1, 0);
      end
      check("ram_en1", ren1, acc1);
      if (acc1) begin
        idx = int'(addr1[AW+1:2]);
        if (wr1) begin
          for (int b = 0; b < 4; b++) if (wstrb1[b]) ref1[idx][8*b +: 8] = wdata1[8*b +: 8];
          exp1_q.push_back(32'h0);
        end else begin
          exp1_q.push_back(ref1[idx]);
        end
        out1++;
      end
      check("occupancy1", (out1 >= 0) && (out1 <= int'(D1)), 1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    {req0, wr0, size0, addr0, wstrb0, wdata0} = '0;
    {req1, wr1, size1, addr1, wstrb1, wdata1} = '0;
    for (int i = 0; i < int'(NW); i++) begin
      mem0[i] = 32'(i) * 32'h11111111;
      mem1[i] = 32'(i) * 32'h11111111;
      ref0[i] = 32'(i) * 32'h11111111;
      ref1[i] = 32'(i) * 32'h11111111;
    end
    prev_acc0 = 1'b0;
    out1      = 0;

    repeat (2) step();
    resetn = 1'b1;

    // Directed checks on u_dut0, which has no delay.
    // Three reads, a partial write, then a read-back.
    req0 = 1'b1; wr0 = 1'b0; size0 = 2'd2; addr0 = 32'h0;
    @(negedge clk);
    check("dir_addr_ok_first", aok0, 1);
    check("dir_no_resp_first", dok0, 0);
    step(); addr0 = 32'h4;
    @(negedge clk);
    check("dir_rd0_ok", dok0, 1);
    check("dir_rd0_data", rdata0, 32'h00000000);
    step(); addr0 = 32'h8;
    @(negedge clk);
    check("dir_rd4_data", rdata0, 32'h11111111);
    step(); wr0 = 1'b1; addr0 = 32'h10; wstrb0 = 4'b0011; wdata0 = 32'hAABBCCDD;
    @(negedge clk);
    check("dir_rd8_data", rdata0, 32'h22222222);
    check("dir_wr_ram_we", rwe0, 4'b0011);
    step(); wr0 = 1'b0; wstrb0 = 4'h0;
    @(negedge clk);
    check("dir_wr_resp_ok", dok0, 1);
    check("dir_wr_resp_data", rdata0, 32'h0);
    step(); req0 = 1'b0;
    @(negedge clk);
    check("dir_rdback_data", rdata0, 32'h4444CCDD);
    step();
    @(negedge clk);
    check("dir_idle_ready", aok0, 1);
    check("dir_idle_no_resp", dok0, 0);

    // Random traffic on both instances, with one reset in the middle.
    for (int cyc = 0; cyc < 400; cyc++) begin
      step();
      resetn = (cyc != 200);
      req0   = ($urandom_range(0, 3) != 0);
      wr0    = $urandom_range(0, 1) == 1;
      size0  = 2'($urandom_range(0, 2));
      addr0  = $urandom();
      wstrb0 = 4'($urandom_range(0, 15));
      wdata0 = $urandom();
      req1   = ($urandom_range(0, 3) != 0);
      wr1    = $urandom_range(0, 1) == 1;
      size1  = 2'($urandom_range(0, 2));
      addr1  = $urandom();
      wstrb1 = 4'($urandom_range(0, 15));
      wdata1 = $urandom();
    end

    // Drain: every outstanding response must arrive within the bound.
    step();
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (40) step();
    check("drain0_empty", exp0_q.size(), 0);
    check("drain1_empty", exp1_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_like_slave.md
# sram_like_slave

Responder for the SRAM-like handshake (req/addr_ok/data_ok) that our pipeline stages use as initiators toward instruction and data memory. It accepts address-phase requests, performs each access on a single-port synchronous RAM, and returns in-order responses with data_ok/rdata. An optional LFSR-driven random delay on both phases stresses the initiators' buffering, cancel and flush logic in simulation and FPGA bring-up.

## Interface
- DEPTH, 4: maximum outstanding requests (power of two, 2..8)
- RAM_AW, 16: RAM word-address width
- DELAY_EN, 0: 1 enables random addr_ok and data_ok stalls
- DELAY_BITS, 2: width of the random stall count (0..2^DELAY_BITS-1 cycles)
- LFSR_SEED, 16'hACE1: LFSR reset value, must be non-zero

- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- sram_req  in  1  request valid
- sram_wr  in  1  1 = write, 0 = read
- sram_size  in  2  0 byte, 1 half, 2 word (informational; byte enables come from wstrb)
- sram_addr  in  32  byte address
- sram_wstrb  in  4  write byte enables
- sram_wdata  in  32  write data
- sram_addr_ok  out  1  address phase accepted this cycle
- sram_data_ok  out  1  one response delivered this cycle
- sram_rdata  out  32  read data, valid when data_ok (0 for write responses)
- ram_en  out  1  RAM access enable
- ram_we  out  4  RAM byte write enables
- ram_addr  out  RAM_AW  RAM word address = sram_addr[RAM_AW+1:2]
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid the cycle after ram_en

## Operation
- Handshake: accept = sram_req & sram_addr_ok. In the accept cycle the RAM is driven combinationally: ram_en=1, ram_we = sram_wr ? sram_wstrb : 4'h0, ram_addr, ram_wdata = sram_wdata. ram_en=0 otherwise.
- sram_addr_ok = (count < DEPTH) & (addr_wait == 0). count excludes a same-cycle pop (conservative: a full queue does not accept even while popping).
- Response queue: DEPTH-entry circular buffer, head/tail pointers wrap modulo DEPTH, count 0..DEPTH. Entry = {is_write, filled, data[31:0]}. Accept pushes at tail with filled=is_write, data=0.
- Fill: the cycle after an accepted read, ram_rdata is written into that entry and filled is set.
- Response: sram_data_ok = (count != 0) & (data_wait == 0) & head_ready, where head_ready = head.filled OR (head is the read accepted last cycle). sram_rdata = bypass ? ram_rdata : head.data. data_ok pops the head. No backpressure: the initiator must take every data_ok.
- Responses are strictly in acceptance order; reads and writes share the queue.
- Delay (DELAY_EN=1): 16-bit Fibonacci LFSR, taps 16,14,13,11, shifts every cycle. addr_wait loads lfsr[DELAY_BITS-1:0] on each accept and decrements to 0; data_wait loads lfsr[2*DELAY_BITS-1:DELAY_BITS] on each data_ok and decrements to 0. With DELAY_EN=0 both stay 0.
- No alignment or range checks; upper address bits are ignored.

## Timing
- Reset (resetn=0 at a clock edge): count=0, head=tail=0, all filled=0, addr_wait=data_wait=0, lfsr=LFSR_SEED. Outputs: sram_addr_ok=0 during the reset cycle, then 1 from the first cycle after release; sram_data_ok=0, sram_rdata=0, ram_en=0, ram_we=0.
- Reset mid-operation discards all outstanding entries; no data_ok is produced for them.
- Minimum latency: accept at cycle T, data_ok at T+1 (read data by bypass). Zero-delay steady state: one accept and one data_ok per cycle.
- Write response: earliest T+1, sram_rdata=0.
- Accept and data_ok in the same cycle: count unchanged; both pointers advance.
- count reaches DEPTH: addr_ok=0 until a data_ok retires an entry; addr_ok returns the following cycle.
- When sram_req=0, addr_ok still reflects readiness (it may be 1 with no request).
- sram_rdata=0 in every cycle without data_ok.

## Test plan
- Zero delay, RAM preloaded word[i]=i*0x11111111: reads to 0x0,0x4,0x8 accepted in cycles 1,2,3 -> data_ok in cycles 2,3,4 with rdata 0x00000000, 0x11111111, 0x22222222.
- Write addr 0x10, wstrb 4'b0011, wdata 0xAABBCCDD over old 0x44444444, then read 0x10 -> write data_ok rdata=0, read returns 0x4444CCDD.
- DEPTH=4, data_wait forced large: four reads accepted, addr_ok=0 on the fifth request; first data_ok re-enables addr_ok the next cycle; all five responses arrive in order.
- DELAY_EN=1, 200 random reads/writes against a bench scoreboard -> every response in order with correct data; count never exceeds DEPTH.
- resetn=0 with 3 outstanding reads -> no data_ok afterward; addr_ok=1 the cycle after release; the next read returns the correct data at T+1.
- Full queue with simultaneous data_ok and req -> request not accepted that cycle, accepted the next cycle.
